// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
//   Single-clock first-word-fall-through FIFO of DEPTH words x WIDTH bits.
//   The storage is a circular buffer addressed by write/read pointers, and an
//   occupancy counter tells the full and empty states apart.
//
// Ports
//   clk       in   rising-edge clock for all state
//   clrn      in   asynchronous reset, active-high (clears pointers, count and
//                  the overflow flag; storage contents are left untouched)
//   read      in   pop request
//   write     in   push request
//   data_in   in   word to push
//   data_out  out  head (oldest) word, combinational from storage
//   ready     out  queue holds at least one word
//   overflow  out  sticky: a write was dropped because the queue was full
// -----------------------------------------------------------------------------
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             read,
  input  logic             write,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             ready,
  output logic             overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0] wp_q, wp_d;
  logic [AW-1:0] rp_q, rp_d;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;

  logic empty;
  logic full;
  logic push;
  logic pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_COUNT);

  // A write into a full queue is still accepted when a pop frees a slot on
  // the same edge; a read of an empty queue is simply ignored.
  assign push = write && (!full || read);
  assign pop  = read && !empty;

  always_comb begin
    wp_d       = wp_q;
    rp_d       = rp_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    if (push) begin
      wp_d = wp_q + 1'b1;
    end
    if (pop) begin
      rp_d = rp_q + 1'b1;
    end

    // Simultaneous push and pop leave the occupancy unchanged.
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end

    if (write && !push) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge clrn) begin
    if (clrn) begin
      wp_q       <= '0;
      rp_q       <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is deliberately kept out of the reset path so it can map onto
  // plain distributed/block memory.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wp_q] <= data_in;
    end
  end

  // Fall-through head: the oldest word is visible without a read strobe.
  assign data_out = mem[rp_q];
  assign ready    = !empty;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_sync_fifo.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo
//   Directed scenarios followed by randomized traffic. The stimulus side keeps
//   a queue-based reference (expected words in order, occupancy, sticky
//   overflow); a separate monitor on the falling edge compares the DUT's
//   ready/overflow/head and retires expected words whenever a pop is
//   presented to the DUT.
// -----------------------------------------------------------------------------
module tb_sync_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 8;

  logic             clk = 1'b0;
  logic             clrn = 1'b1;
  logic             read = 1'b0;
  logic             write = 1'b0;
  logic [WIDTH-1:0] data_in = '0;
  logic [WIDTH-1:0] data_out;
  logic             ready;
  logic             overflow;

  always #5 clk = ~clk;

  sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .clrn     (clrn),
    .read     (read),
    .write    (write),
    .data_in  (data_in),
    .data_out (data_out),
    .ready    (ready),
    .overflow (overflow)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model
  logic [WIDTH-1:0] exp_q [$];
  int               mdl_cnt = 0;
  bit               mdl_ovf = 1'b0;
  bit               started = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // One clock of stimulus. Entered #1 after a rising edge, returns #1 after
  // the next one with the model advanced to match.
  task automatic cycle(input bit rd, input bit wr, input logic [WIDTH-1:0] d);
    bit push_ok;
    bit pop_ok;
    read    = rd;
    write   = wr;
    data_in = d;
    pop_ok  = rd && (mdl_cnt > 0);
    push_ok = wr && ((mdl_cnt < DEPTH) || rd);
    if (push_ok) exp_q.push_back(d);
    @(posedge clk);
    #1;
    if (wr && !push_ok) mdl_ovf = 1'b1;
    mdl_cnt = mdl_cnt + int'(push_ok) - int'(pop_ok);
    $display("txn rd=%0d wr=%0d din=%02h push=%0d pop=%0d cnt=%0d ovf=%0d",
             rd, wr, d, push_ok, pop_ok, mdl_cnt, mdl_ovf);
    read  = 1'b0;
    write = 1'b0;
  endtask

  task automatic do_reset();
    clrn    = 1'b1;
    read    = 1'b0;
    write   = 1'b0;
    data_in = '0;
    exp_q.delete();
    mdl_cnt = 0;
    mdl_ovf = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    clrn = 1'b0;
    check("rst_ready", ready, 0);
    check("rst_overflow", overflow, 0);
  endtask

  task automatic drain();
    for (int i = 0; i < 2 * DEPTH + 2 && mdl_cnt > 0; i++) cycle(1'b1, 1'b0, '0);
    check("drain_cnt", mdl_cnt, 0);
  endtask

  // Monitor: checks state mid-cycle and retires the head on every pop.
  always @(negedge clk) begin
    if (started && !clrn) begin
      check("ready", ready, (mdl_cnt != 0));
      check("overflow", overflow, mdl_ovf);
      if (mdl_cnt > 0) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL head: scoreboard empty, got %0h", data_out);
        end else begin
          check("head", data_out, exp_q[0]);
        end
      end
      if (read && ready && exp_q.size() > 0) void'(exp_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WIDTH-1:0] v;
    int wp, rp;

    // 1. Reset, idle
    do_reset();
    started = 1'b1;
    cycle(1'b0, 1'b0, '0);
    check("t1_ready", ready, 0);

    // 2. Fill with E0..E7
    for (int i = 0; i < DEPTH; i++) begin
      v = 8'hE0 + 8'(i);
      cycle(1'b0, 1'b1, v);
      check("t2_ready", ready, 1);
      check("t2_head", data_out, 8'hE0);
    end
    check("t2_overflow", overflow, 0);

    // 3. Overflow on full, then drain in order
    cycle(1'b0, 1'b1, 8'hE8);
    check("t3_overflow", overflow, 1);
    check("t3_head", data_out, 8'hE0);
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, '0);
    check("t3_ready_empty", ready, 0);
    check("t3_overflow_sticky", overflow, 1);
    cycle(1'b1, 1'b0, '0);  // read while empty: ignored
    check("t3_empty_read", ready, 0);

    // 4. Four entries, two simultaneous read+write edges
    do_reset();
    for (int i = 0; i < 4; i++) begin
      v = 8'hE0 + 8'(i);
      cycle(1'b0, 1'b1, v);
    end
    cycle(1'b1, 1'b1, 8'hE4);
    cycle(1'b1, 1'b1, 8'hE5);
    check("t4_head", data_out, 8'hE2);
    check("t4_cnt", mdl_cnt, 4);
    drain();
    check("t4_ready", ready, 0);

    // 5. Read+write on empty
    do_reset();
    cycle(1'b1, 1'b1, 8'hA5);
    check("t5_ready", ready, 1);
    check("t5_head", data_out, 8'hA5);
    drain();

    // 6a. Read+write on full
    do_reset();
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, 8'h10 + 8'(i));
    cycle(1'b1, 1'b1, 8'hF0);
    check("t6_overflow", overflow, 0);
    check("t6_head", data_out, 8'h11);
    drain();

    // 6b. Three full fill/drain rounds exercise pointer wrap
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, 8'(r * 16 + i + 3));
      for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, '0);
    end
    check("t6_wrap_empty", ready, 0);

    // 6c. Asynchronous reset mid-stream with overflow set
    for (int i = 0; i < DEPTH + 1; i++) cycle(1'b0, 1'b1, 8'h40 + 8'(i));
    check("t6_pre_ready", ready, 1);
    check("t6_pre_ovf", overflow, 1);
    #2;
    clrn = 1'b1;
    exp_q.delete();
    mdl_cnt = 0;
    mdl_ovf = 1'b0;
    #1;
    check("t6_async_ready", ready, 0);
    check("t6_async_ovf", overflow, 0);
    @(posedge clk);
    #1;
    clrn = 1'b0;

    // Randomized traffic in phases biased toward full, empty and balanced
    for (int ph = 0; ph < 4; ph++) begin
      case (ph)
        0: begin wp = 80; rp = 20; end
        1: begin wp = 20; rp = 80; end
        2: begin wp = 50; rp = 50; end
        default: begin wp = 90; rp = 90; end
      endcase
      for (int i = 0; i < 150; i++) begin
        cycle(($urandom_range(99) < rp), ($urandom_range(99) < wp), WIDTH'($urandom));
      end
    end

    drain();
    cycle(1'b0, 1'b0, '0);
    check("sb_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sync_fifo.md
Name: sync_fifo

Overview:
- Single-clock first-in/first-out queue of DEPTH words of WIDTH bits, built from a circular buffer with read/write pointers and an occupancy count.
- Sits between a producer (write side) and a consumer (read side) in the same clock domain.
- Head word is always visible on data_out (first-word fall-through).
- Reports data availability (ready) and a sticky error when a write is lost because the queue is full (overflow).

Parameters:
- WIDTH, 8, data word width in bits.
- DEPTH, 8, number of storage entries; must be a power of two, at least 2.

Ports (positional order is fixed as listed):
- clk  input  1  rising-edge clock for all state.
- clrn  input  1  asynchronous reset, active-high. Clears pointers, count and overflow immediately when high.
- read  input  1  pop request, sampled on the rising clk edge.
- write  input  1  push request, sampled on the rising clk edge.
- data_in  input  WIDTH  word to push.
- data_out  output  WIDTH  current head word (oldest entry), combinational from storage.
- ready  output  1  high when the queue holds at least one word.
- overflow  output  1  sticky flag: a write was dropped because the queue was full.

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset values:
  - write pointer, read pointer and count = 0
  - ready = 0, overflow = 0
  - storage contents not cleared; data_out is don't-care while empty.
- Internal state:
  - wp, rp: log2(DEPTH) bits each, wrap modulo DEPTH.
  - count: log2(DEPTH)+1 bits, range 0..DEPTH.
  - empty = (count == 0); full = (count == DEPTH).
- Outputs: ready = !empty. data_out = mem[rp], combinational, so zero-latency head visibility. A pushed word appears on data_out the cycle after the push edge if the queue was empty.
- Per rising edge, with clrn low:
  - Push accepted when write && (!full || read). Action: mem[wp] <= data_in; wp <= wp+1.
  - Pop accepted when read && !empty. Action: rp <= rp+1.
  - count changes +1 for push only, -1 for pop only, unchanged for both or neither.
- Boundary cases:
  - Read while empty: ignored, no pointer or count change, no error flag.
  - Write while full, no read: word dropped, pointers and count unchanged, overflow <= 1.
  - Read+write while full: both accepted; count stays DEPTH, no overflow.
  - Read+write while empty: push accepted, pop ignored; count becomes 1.
- overflow clears only on reset.
- Reset asserted mid-operation: queue empties immediately (asynchronous); contents are lost logically.

Test Plan:
1. Reset high, then low; no requests -> ready=0, overflow=0, count=0.
2. Write 0xE0..0xE7 on 8 consecutive edges, read=0 -> ready=1 after first edge; data_out=0xE0 throughout; full after 8th edge; overflow=0.
3. From full, write 0xE8 with read=0 -> word dropped, overflow=1 and stays 1. Then 8 reads -> data_out sequence 0xE0..0xE7, ready=0 after 8th read.
4. Fill to 4 entries (0xE0..0xE3), then read+write 0xE4, 0xE5 simultaneously for 2 edges -> count stays 4, data_out 0xE2 after those edges; drain order 0xE2, 0xE3, 0xE4, 0xE5.
5. Empty queue with read+write 0xA5 on one edge -> count=1, data_out=0xA5, ready=1.
6. Full queue with read+write 0xF0 -> count=DEPTH, overflow stays 0. Wrap-around check: after 3 full fill/drain cycles, data order is still preserved. Asserting clrn mid-stream -> ready and overflow drop to 0 immediately, without waiting for a clock edge.
